// File: rtl/i_multi_stream_prefetcher.sv
// Multi-stream instruction prefetch buffer: answers I-cache miss lookups from stream heads
// and keeps each allocated stream topped up with line-sized AXI read bursts.
module i_multi_stream_prefetcher #(
   parameter int ADDR_WIDTH         = 32,
   parameter int DATA_WIDTH         = 32,
   parameter int BLOCK_OFFSET_WIDTH = 2,
   parameter int NUM_STREAMS        = 4,
   parameter int DEPTH              = 4,
   parameter int AXI_ID             = 2
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              flush,
   input  logic                                              miss_valid,
   input  logic [ADDR_WIDTH-1:0]                             miss_addr,
   output logic                                              resp_valid,
   output logic                                              resp_hit,
   output logic [(1<<BLOCK_OFFSET_WIDTH)*DATA_WIDTH-1:0]     resp_line,
   output logic                                              arvalid,
   input  logic                                              arready,
   output logic [ADDR_WIDTH-1:0]                             araddr,
   output logic [7:0]                                        arlen,
   output logic [3:0]                                        arid,
   input  logic                                              rvalid,
   output logic                                              rready,
   input  logic [DATA_WIDTH-1:0]                             rdata,
   input  logic                                              rlast,
   input  logic [3:0]                                        rid
);
   localparam int LINE_WORDS = 1 << BLOCK_OFFSET_WIDTH;
   localparam int LINE_W     = LINE_WORDS * DATA_WIDTH;
   localparam int OFF_W      = BLOCK_OFFSET_WIDTH + 2;
   localparam int LA_W       = ADDR_WIDTH - OFF_W;
   localparam int PTR_W      = $clog2(DEPTH);
   localparam int CNT_W      = $clog2(DEPTH + 1);
   localparam int SID_W      = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
   localparam int BEAT_W     = BLOCK_OFFSET_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} fetch_state_t;

   logic [LA_W-1:0]       r_next_la [NUM_STREAMS];
   logic [PTR_W-1:0]      r_head    [NUM_STREAMS];
   logic [PTR_W-1:0]      r_tail    [NUM_STREAMS];
   logic [CNT_W-1:0]      r_count   [NUM_STREAMS];
   logic [SID_W-1:0]      r_age     [NUM_STREAMS];
   logic [NUM_STREAMS-1:0] r_pend;
   logic [NUM_STREAMS-1:0] r_alloc;
   logic [LINE_W-1:0]     r_data    [NUM_STREAMS][DEPTH];
   logic [LA_W-1:0]       r_tag     [NUM_STREAMS][DEPTH];

   fetch_state_t          r_state, w_state_nxt;
   logic [SID_W-1:0]      r_tgt;
   logic                  r_abandon;
   logic [BEAT_W-1:0]     r_beat;
   logic [LINE_W-1:0]     r_buf;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [3:0]            r_arid;
   logic                  r_resp_valid, r_resp_hit;
   logic [LINE_W-1:0]     r_resp_line;

   logic [LA_W-1:0]       w_la;
   logic                  w_hit, w_free, w_cand, w_lookup, w_pop, w_alloc, w_touch;
   logic [SID_W-1:0]      w_hit_idx, w_free_idx, w_lru_idx, w_cand_idx, w_alloc_idx, w_touch_idx;
   logic                  w_beat, w_tgt_kill, w_fetch_start, w_fetch_end, w_push;
   logic [LINE_W-1:0]     w_line;
   logic                  w_unused_off;

   assign w_la         = miss_addr[ADDR_WIDTH-1:OFF_W];
   assign w_unused_off = ^miss_addr[OFF_W-1:0];

   // Scanning downwards leaves the lowest matching index in each result.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_idx  = '0;
      w_free     = 1'b0;
      w_free_idx = '0;
      w_lru_idx  = '0;
      for (int s = NUM_STREAMS - 1; s >= 0; s--) begin
         if (r_count[s] != '0 && r_tag[s][r_head[s]] == w_la) begin
            w_hit     = 1'b1;
            w_hit_idx = SID_W'(s);
         end
         if (r_count[s] == '0 && !r_pend[s]) begin
            w_free     = 1'b1;
            w_free_idx = SID_W'(s);
         end
         if (r_age[s] == SID_W'(NUM_STREAMS - 1)) w_lru_idx = SID_W'(s);
      end
   end

   assign w_lookup    = miss_valid && !flush;
   assign w_pop       = w_lookup && w_hit;
   assign w_alloc     = w_lookup && !w_hit;
   assign w_alloc_idx = w_free ? w_free_idx : w_lru_idx;
   assign w_touch     = w_pop || w_alloc;
   assign w_touch_idx = w_pop ? w_hit_idx : w_alloc_idx;

   // A stream being reallocated this cycle is skipped so its old next_la is never fetched.
   always_comb begin
      w_cand     = 1'b0;
      w_cand_idx = '0;
      for (int s = NUM_STREAMS - 1; s >= 0; s--) begin
         if (r_alloc[s] && r_count[s] < CNT_W'(DEPTH) && !r_pend[s] &&
             !(w_alloc && w_alloc_idx == SID_W'(s))) begin
            w_cand     = 1'b1;
            w_cand_idx = SID_W'(s);
         end
      end
   end

   assign w_beat        = rvalid && (rid == 4'(AXI_ID));
   assign w_tgt_kill    = flush || (w_alloc && w_alloc_idx == r_tgt);
   assign w_fetch_start = (r_state == S_IDLE) && w_cand && !flush;
   assign w_fetch_end   = (r_state == S_DATA) && w_beat && rlast;
   assign w_push        = w_fetch_end && !w_tgt_kill && (r_beat == BEAT_W'(LINE_WORDS - 1));

   always_comb begin
      w_line = r_buf;
      w_line[r_beat*DATA_WIDTH +: DATA_WIDTH] = rdata;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_fetch_start) w_state_nxt = S_ADDR;
         S_ADDR:  if (arready) w_state_nxt = (r_abandon || w_tgt_kill) ? S_DRAIN : S_DATA;
         S_DATA: begin
            if (w_beat && rlast) w_state_nxt = S_IDLE;
            else if (w_tgt_kill) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: if (w_beat && rlast) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_STREAMS; s++) begin
            r_next_la[s] <= '0;
            r_head[s]    <= '0;
            r_tail[s]    <= '0;
            r_count[s]   <= '0;
            r_age[s]     <= SID_W'(s);
         end
         r_pend       <= '0;
         r_alloc      <= '0;
         r_state      <= S_IDLE;
         r_tgt        <= '0;
         r_abandon    <= 1'b0;
         r_beat       <= '0;
         r_buf        <= '0;
         r_araddr     <= '0;
         r_arid       <= '0;
         r_resp_valid <= 1'b0;
         r_resp_hit   <= 1'b0;
         r_resp_line  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_resp_valid <= miss_valid;
         r_resp_hit   <= w_pop;
         r_resp_line  <= w_pop ? r_data[w_hit_idx][r_head[w_hit_idx]] : '0;

         for (int s = 0; s < NUM_STREAMS; s++) begin
            if (flush) begin
               r_count[s] <= '0;
               r_pend[s]  <= 1'b0;
               r_alloc[s] <= 1'b0;
            end else if (w_alloc && w_alloc_idx == SID_W'(s)) begin
               r_count[s]   <= '0;
               r_head[s]    <= '0;
               r_tail[s]    <= '0;
               r_pend[s]    <= 1'b0;
               r_alloc[s]   <= 1'b1;
               r_next_la[s] <= w_la + LA_W'(1);
            end else begin
               if (w_pop && w_hit_idx == SID_W'(s)) r_head[s] <= r_head[s] + PTR_W'(1);
               if (w_push && r_tgt == SID_W'(s)) begin
                  r_tail[s]    <= r_tail[s] + PTR_W'(1);
                  r_next_la[s] <= r_next_la[s] + LA_W'(1);
               end
               r_count[s] <= r_count[s] + CNT_W'(w_push && r_tgt == SID_W'(s))
                                        - CNT_W'(w_pop && w_hit_idx == SID_W'(s));
               if (w_fetch_start && w_cand_idx == SID_W'(s)) r_pend[s] <= 1'b1;
               else if (w_fetch_end && r_tgt == SID_W'(s)) r_pend[s] <= 1'b0;
            end
            if (w_touch) begin
               if (SID_W'(s) == w_touch_idx) r_age[s] <= '0;
               else if (r_age[s] < r_age[w_touch_idx]) r_age[s] <= r_age[s] + SID_W'(1);
            end
         end

         if (w_fetch_start) begin
            r_tgt     <= w_cand_idx;
            r_araddr  <= {r_next_la[w_cand_idx], {OFF_W{1'b0}}};
            r_arid    <= 4'(AXI_ID);
            r_abandon <= 1'b0;
            r_beat    <= '0;
         end
         // A target killed while the address is still waiting is drained after the handshake.
         if (r_state == S_ADDR && w_tgt_kill) r_abandon <= 1'b1;
         if (r_state == S_DATA && w_beat && r_beat < BEAT_W'(LINE_WORDS)) begin
            r_buf[r_beat*DATA_WIDTH +: DATA_WIDTH] <= rdata;
            r_beat <= r_beat + BEAT_W'(1);
         end
      end
   end

   // NOTE: line storage has no reset; r_count gates every read, so stale contents are never seen.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_data[r_tgt][r_tail[r_tgt]] <= w_line;
         r_tag[r_tgt][r_tail[r_tgt]]  <= r_next_la[r_tgt];
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_hit   = r_resp_hit;
   assign resp_line  = r_resp_line;
   assign arvalid    = (r_state == S_ADDR);
   assign araddr     = r_araddr;
   assign arlen      = 8'(LINE_WORDS - 1);
   assign arid       = r_arid;
   assign rready     = (r_state == S_DATA) || (r_state == S_DRAIN);
endmodule

// File: tb/tb_i_multi_stream_prefetcher.sv
// Directed bench for the multi-stream prefetcher; the bench itself plays the AXI memory,
// whose word at byte address a is a ^ 32'h5A5A0000.
module tb_i_multi_stream_prefetcher;
   localparam int M_NORMAL   = 0;
   localparam int M_FOREIGN  = 1;
   localparam int M_COINCIDE = 2;
   localparam int M_FLUSH    = 3;

   logic         clk = 1'b0;
   logic         rst, flush, miss_valid;
   logic [31:0]  miss_addr;
   logic         resp_valid, resp_hit;
   logic [127:0] resp_line;
   logic         arvalid, arready;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [3:0]   arid;
   logic         rvalid, rready, rlast;
   logic [31:0]  rdata;
   logic [3:0]   rid;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   i_multi_stream_prefetcher #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_OFFSET_WIDTH(2),
      .NUM_STREAMS(4), .DEPTH(4), .AXI_ID(2)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .miss_valid(miss_valid), .miss_addr(miss_addr),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_line(resp_line),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arid(arid),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rid(rid)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [127:0] line_of(input logic [31:0] a);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem_word({a[31:4], 4'h0} + 32'(4 * i));
      return l;
   endfunction

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1; flush = 1'b0; miss_valid = 1'b0; miss_addr = '0;
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic lookup(input string tag, input logic [31:0] addr,
                         input logic exp_hit, input logic [127:0] exp_line);
      miss_valid = 1'b1;
      miss_addr  = addr;
      @(negedge clk);
      miss_valid = 1'b0;
      check({tag, "_valid"}, resp_valid, 1'b1);
      check({tag, "_hit"}, resp_hit, exp_hit);
      check({tag, "_line"}, resp_line, exp_line);
   endtask

   task automatic expect_idle(input string tag);
      repeat (4) @(negedge clk);
      check({tag, "_no_burst"}, arvalid, 1'b0);
   endtask

   task automatic burst(input string tag, input logic [31:0] addr, input int mode);
      int n;
      n = 0;
      while (arvalid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_arvalid"}, arvalid, 1'b1);
      if (arvalid !== 1'b1) return;
      check({tag, "_araddr"}, araddr, addr);
      check({tag, "_arlen"}, arlen, 8'd3);
      check({tag, "_arid"}, arid, 4'd2);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      check({tag, "_rready"}, rready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (mode == M_FOREIGN) begin
            rvalid = 1'b1; rid = 4'd5; rdata = 32'hBAD0_0000 + 32'(i); rlast = (i == 3);
            @(negedge clk);
         end
         if (mode == M_FLUSH && i == 2) begin
            rvalid = 1'b0; rlast = 1'b0;
            flush = 1'b1; miss_valid = 1'b1; miss_addr = 32'h1010;
            @(negedge clk);
            flush = 1'b0; miss_valid = 1'b0;
            check({tag, "_flush_valid"}, resp_valid, 1'b1);
            check({tag, "_flush_hit"}, resp_hit, 1'b0);
            check({tag, "_flush_line"}, resp_line, 128'd0);
            check({tag, "_drain_rready"}, rready, 1'b1);
         end
         rvalid = 1'b1; rid = 4'd2; rdata = mem_word(addr + 32'(4 * i)); rlast = (i == 3);
         if (mode == M_COINCIDE && i == 3) begin
            miss_valid = 1'b1;
            miss_addr  = 32'h1010;
         end
         @(negedge clk);
         rvalid = 1'b0; rlast = 1'b0; miss_valid = 1'b0;
         if (mode == M_COINCIDE && i == 3) begin
            check({tag, "_hit"}, resp_hit, 1'b1);
            check({tag, "_line"}, resp_line, line_of(32'h1010));
         end
      end
      rid = '0; rdata = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; miss_valid = 1'b0; miss_addr = '0;
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0;
      reset_dut();
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_hit", resp_hit, 1'b0);
      check("rst_resp_line", resp_line, 128'd0);
      check("rst_arvalid", arvalid, 1'b0);
      check("rst_rready", rready, 1'b0);
      check("rst_araddr", araddr, 32'd0);
      check("rst_arid", arid, 4'd0);
      check("rst_arlen", arlen, 8'd3);

      // first miss allocates stream 0, which then fetches the four following lines
      lookup("a_miss", 32'h1000, 1'b0, 128'd0);
      @(negedge clk);
      check("a_resp_one_cycle", resp_valid, 1'b0);
      burst("a_b1", 32'h1010, M_NORMAL);
      burst("a_b2", 32'h1020, M_NORMAL);
      burst("a_b3", 32'h1030, M_NORMAL);
      burst("a_b4", 32'h1040, M_NORMAL);
      expect_idle("a_full");
      lookup("a_hit", 32'h1014, 1'b1, 128'h5A5A101C_5A5A1018_5A5A1014_5A5A1010);
      burst("a_refill", 32'h1050, M_NORMAL);
      lookup("a_deep", 32'h1030, 1'b0, 128'd0);

      // fill every stream, touch stream 0, then evict the LRU stream 1
      reset_dut();
      for (int k = 1; k <= 4; k++) begin
         lookup("b_alloc", 32'(k) << 12, 1'b0, 128'd0);
         for (int j = 1; j <= 4; j++) burst("b_fill", (32'(k) << 12) + (32'(j) << 4), M_NORMAL);
      end
      expect_idle("b_full");
      lookup("b_hit_s0", 32'h1010, 1'b1, line_of(32'h1010));
      burst("b_refill_s0", 32'h1050, M_NORMAL);
      lookup("b_miss_5000", 32'h5000, 1'b0, 128'd0);
      for (int j = 1; j <= 4; j++) burst("b_fill_5", 32'h5000 + (32'(j) << 4), M_NORMAL);
      lookup("b_hit_s3", 32'h4010, 1'b1, line_of(32'h4010));
      burst("b_refill_s3", 32'h4050, M_NORMAL);
      lookup("b_evicted", 32'h2010, 1'b0, 128'd0);

      // pop and push on the same stream in one cycle
      reset_dut();
      lookup("c_miss", 32'h1000, 1'b0, 128'd0);
      burst("c_b1", 32'h1010, M_NORMAL);
      burst("c_b2", 32'h1020, M_NORMAL);
      burst("c_b3", 32'h1030, M_NORMAL);
      burst("c_coincide", 32'h1040, M_COINCIDE);
      lookup("c_hit_1020", 32'h1020, 1'b1, line_of(32'h1020));
      lookup("c_hit_1030", 32'h1030, 1'b1, line_of(32'h1030));
      lookup("c_hit_1040", 32'h1040, 1'b1, line_of(32'h1040));
      check("c_ar_hold_valid", arvalid, 1'b1);
      check("c_ar_hold_addr", araddr, 32'h1050);

      // flush in the middle of a data phase
      reset_dut();
      lookup("d_miss", 32'h1000, 1'b0, 128'd0);
      burst("d_b1", 32'h1010, M_NORMAL);
      burst("d_flush", 32'h1020, M_FLUSH);
      check("d_drain_done", rready, 1'b0);
      expect_idle("d_flushed");
      lookup("d_after", 32'h1020, 1'b0, 128'd0);
      burst("d_realloc", 32'h1030, M_NORMAL);

      // beats carrying a foreign ID are ignored
      reset_dut();
      lookup("e_miss", 32'h2000, 1'b0, 128'd0);
      burst("e_foreign", 32'h2010, M_FOREIGN);
      burst("e_b2", 32'h2020, M_NORMAL);
      burst("e_b3", 32'h2030, M_NORMAL);
      burst("e_b4", 32'h2040, M_NORMAL);
      lookup("e_hit", 32'h2010, 1'b1, 128'h5A5A201C_5A5A2018_5A5A2014_5A5A2010);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
